// File: rtl/fetch_stage.sv
// Instruction fetch stage of the pipelined core.
// Holds the PC and presents it to the combinational, big-endian instruction memory.
// Latches the returned word together with PC+4 into the IF/ID register.
// Handles stall, flush and redirect requests.
// A small FSM inserts one bubble after reset and parks the stage in a sticky
// HALTED state on a halt request or an illegal fetch address.

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd100,
    parameter int          IMEM_BYTES = 16384
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt_req,
    input  logic [31:0] i_imem_instr,
    output logic [31:0] o_imem_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_fetch_fault,
    output logic        o_halted,
    output logic [31:0] o_fetch_count
);

    // Highest byte address from which a full word can still be fetched
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] r_ifIdInstr;
    logic [31:0] r_ifIdPc4;
    logic        r_ifIdValid;
    logic        r_fault;
    logic [31:0] r_fetchCount;

    logic [31:0] w_pcNext;
    logic [31:0] w_instrNext;
    logic [31:0] w_pc4Next;
    logic        w_validNext;
    logic        w_faultNext;
    logic [31:0] w_countNext;
    logic [31:0] w_pcPlus4;

    assign w_pcPlus4 = r_pc + 32'd4;

    // Next-state and next-register decode.
    // IF/ID defaults to a bubble, so every path that does not load a real word squashes it.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_instrNext = 32'h0;
        w_pc4Next   = 32'h0;
        w_validNext = 1'b0;
        w_faultNext = r_fault;
        w_countNext = r_fetchCount;
        case (r_state)
            ST_START: begin
                w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                if (i_halt_req) begin
                    w_stateNext = ST_HALTED;
                end else if (i_redirect_valid) begin
                    if (i_redirect_pc[1:0] != 2'b00) begin
                        w_faultNext = 1'b1;
                        w_stateNext = ST_HALTED;
                    end else begin
                        w_pcNext = i_redirect_pc;
                    end
                end else if (i_stall) begin
                    if (!i_flush) begin
                        w_instrNext = r_ifIdInstr;
                        w_pc4Next   = r_ifIdPc4;
                        w_validNext = r_ifIdValid;
                    end
                end else if (r_pc > LAST_PC) begin
                    w_faultNext = 1'b1;
                    w_stateNext = ST_HALTED;
                end else begin
                    w_pcNext = w_pcPlus4;
                    if (!i_flush) begin
                        w_instrNext = i_imem_instr;
                        w_pc4Next   = w_pcPlus4;
                        w_validNext = 1'b1;
                        w_countNext = r_fetchCount + 32'd1;
                    end
                end
            end
            ST_HALTED: begin
                w_stateNext = ST_HALTED;
            end
            default: begin
                w_stateNext = ST_START;
            end
        endcase
    end

    // State, PC, IF/ID and counter registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_START;
            r_pc         <= RESET_PC;
            r_ifIdInstr  <= 32'h0;
            r_ifIdPc4    <= 32'h0;
            r_ifIdValid  <= 1'b0;
            r_fault      <= 1'b0;
            r_fetchCount <= 32'h0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_ifIdInstr  <= w_instrNext;
            r_ifIdPc4    <= w_pc4Next;
            r_ifIdValid  <= w_validNext;
            r_fault      <= w_faultNext;
            r_fetchCount <= w_countNext;
        end
    end

    assign o_imem_pc     = r_pc;
    assign o_if_id_instr = r_ifIdInstr;
    assign o_if_id_pc4   = r_ifIdPc4;
    assign o_if_id_valid = r_ifIdValid;
    assign o_fetch_fault = r_fault;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_fetch_count = r_fetchCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage.
// A byte-array instruction memory feeds the DUT.
// A cycle-level reference model applies the fetch rules in priority order.
// Directed scenarios are followed by randomized traffic.

module tb_fetch_stage;

    localparam int MEM_BYTES = 16384;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        haltReq;
    logic [31:0] imemInstr;
    logic [31:0] imemPc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic        ifIdValid;
    logic        fetchFault;
    logic        halted;
    logic [31:0] fetchCount;

    logic [7:0]  mem [0:MEM_BYTES-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPc4;
    logic        mValid;
    logic        mFault;
    logic        mHalted;
    logic [31:0] mCount;
    logic        mStarted;

    fetch_stage #(
        .RESET_PC   (32'd100),
        .IMEM_BYTES (MEM_BYTES)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .i_halt_req       (haltReq),
        .i_imem_instr     (imemInstr),
        .o_imem_pc        (imemPc),
        .o_if_id_instr    (ifIdInstr),
        .o_if_id_pc4      (ifIdPc4),
        .o_if_id_valid    (ifIdValid),
        .o_fetch_fault    (fetchFault),
        .o_halted         (halted),
        .o_fetch_count    (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian combinational instruction memory; out-of-range reads return zero
    always_comb begin
        imemInstr = 32'h0;
        if (imemPc <= 32'd16380)
            imemInstr = {mem[imemPc[13:0]], mem[imemPc[13:0] + 14'd1],
                         mem[imemPc[13:0] + 14'd2], mem[imemPc[13:0] + 14'd3]};
    end

    function automatic logic [31:0] readWord(input logic [31:0] addr);
        logic [13:0] a;
        a = addr[13:0];
        return {mem[a], mem[a + 14'd1], mem[a + 14'd2], mem[a + 14'd3]};
    endfunction

    task automatic putWord(input int addr, input logic [31:0] w);
        mem[addr]     = w[31:24];
        mem[addr + 1] = w[23:16];
        mem[addr + 2] = w[15:8];
        mem[addr + 3] = w[7:0];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic bubbleModel();
        mInstr = 32'h0;
        mPc4   = 32'h0;
        mValid = 1'b0;
    endtask

    // One clock of the reference model using the inputs about to be sampled
    task automatic stepModel();
        logic [31:0] word;
        word = readWord(mPc);
        if (reset) begin
            mPc = 32'd100;
            bubbleModel();
            mFault   = 1'b0;
            mHalted  = 1'b0;
            mCount   = 32'h0;
            mStarted = 1'b0;
        end else if (!mStarted) begin
            mStarted = 1'b1;
            bubbleModel();
        end else if (mHalted) begin
            bubbleModel();
        end else if (haltReq) begin
            bubbleModel();
            mHalted = 1'b1;
        end else if (redirectValid) begin
            bubbleModel();
            if (redirectPc % 4 != 0) begin
                mFault  = 1'b1;
                mHalted = 1'b1;
            end else begin
                mPc = redirectPc;
            end
        end else if (stall) begin
            if (flush) bubbleModel();
        end else if (mPc > MEM_BYTES - 4) begin
            bubbleModel();
            mFault  = 1'b1;
            mHalted = 1'b1;
        end else begin
            if (flush) begin
                bubbleModel();
            end else begin
                mInstr = word;
                mPc4   = mPc + 4;
                mValid = 1'b1;
                mCount = mCount + 1;
            end
            mPc = mPc + 4;
        end
    endtask

    task automatic checkAll();
        checkOutput("imem_pc", imemPc, mPc);
        checkOutput("if_id_instr", ifIdInstr, mInstr);
        checkOutput("if_id_pc4", ifIdPc4, mPc4);
        checkOutput("if_id_valid", 32'(ifIdValid), 32'(mValid));
        checkOutput("fetch_fault", 32'(fetchFault), 32'(mFault));
        checkOutput("halted", 32'(halted), 32'(mHalted));
        checkOutput("fetch_count", fetchCount, mCount);
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare everything
    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic rv, input logic [31:0] rpc, input logic hr);
        reset         = rst;
        stall         = stl;
        flush         = fl;
        redirectValid = rv;
        redirectPc    = rpc;
        haltReq       = hr;
        stepModel();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        int r;
        logic [31:0] target;

        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        putWord(100, 32'h48080000);
        putWord(104, 32'h48090004);
        putWord(200, 32'h24130005);

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirectValid = 1'b0; redirectPc = 32'h0; haltReq = 1'b0;
        mPc = 32'd100; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
        mFault = 1'b0; mHalted = 1'b0; mCount = 32'h0; mStarted = 1'b0;
        #1;

        // Reset and first fetches
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_pc", imemPc, 32'd100);
        checkOutput("reset_valid", 32'(ifIdValid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("start_bubble", 32'(ifIdValid), 32'd0);
        checkOutput("start_pc_hold", imemPc, 32'd100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("first_instr", ifIdInstr, 32'h48080000);
        checkOutput("first_pc4", ifIdPc4, 32'd104);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("second_instr", ifIdInstr, 32'h48090004);
        checkOutput("second_pc4", ifIdPc4, 32'd108);
        checkOutput("count_two", fetchCount, 32'd2);

        // Stall two cycles
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("stall_pc", imemPc, 32'd108);
        checkOutput("stall_instr", ifIdInstr, 32'h48090004);
        checkOutput("stall_count", fetchCount, 32'd2);

        // Redirect overrides stall
        applyStimulus(0, 1, 0, 1, 32'd200, 0);
        checkOutput("redir_pc", imemPc, 32'd200);
        checkOutput("redir_bubble", 32'(ifIdValid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("redir_instr", ifIdInstr, 32'h24130005);
        checkOutput("redir_pc4", ifIdPc4, 32'd204);

        // Misaligned redirect faults and freezes the stage
        applyStimulus(0, 0, 0, 1, 32'h66, 0);
        checkOutput("misal_fault", 32'(fetchFault), 32'd1);
        checkOutput("misal_halted", 32'(halted), 32'd1);
        checkOutput("misal_pc", imemPc, 32'd204);
        applyStimulus(0, 0, 0, 1, 32'd300, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("halt_pc_frozen", imemPc, 32'd204);
        checkOutput("halt_count_frozen", fetchCount, 32'd3);

        // Reset wins over a simultaneous redirect
        applyStimulus(1, 0, 0, 1, 32'd400, 0);
        checkOutput("rst_redir_pc", imemPc, 32'd100);
        checkOutput("rst_fault_clr", 32'(fetchFault), 32'd0);
        checkOutput("rst_count_clr", fetchCount, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_start_bubble", 32'(ifIdValid), 32'd0);

        // Run off the end of instruction memory
        applyStimulus(0, 0, 0, 1, 32'd16376, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("end_pc", imemPc, 32'd16384);
        checkOutput("end_last_pc4", ifIdPc4, 32'd16384);
        checkOutput("end_last_valid", 32'(ifIdValid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("end_fault", 32'(fetchFault), 32'd1);
        checkOutput("end_halted", 32'(halted), 32'd1);
        checkOutput("end_no_valid", 32'(ifIdValid), 32'd0);
        checkOutput("end_count", fetchCount, 32'd2);

        // Randomized traffic against the model
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            target = {18'h0, 12'($urandom), 2'b00};
            if ($urandom_range(0, 15) == 0) target = 32'($urandom_range(16370, 16400));
            applyStimulus(r < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                          $urandom_range(0, 9) == 0, target, r == 99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
